// File: rtl/adder_pkg.sv
// Shared definitions for the registered 4-bit adder.
// Contents:
//   ADDER_WIDTH  - operand width in bits
//   nibble_t     - one operand or raw sum
//   nibble_sum_t - carry-out concatenated above the sum
package adder_pkg;
  localparam int ADDER_WIDTH = 4;
  typedef logic [ADDER_WIDTH-1:0] nibble_t;
  typedef logic [ADDER_WIDTH:0]   nibble_sum_t;
endpackage

// File: rtl/adder_4bit_if.sv
// Bundle of the adder's operand and result bits.
// It lets a driver and a consumer pass the bit-level adder signals as one port.
// Modports:
//   master - drives the operands and carry-in; reads the sum and carry-out
//   slave  - reads the operands; drives the sum and carry-out
interface adder_4bit_if;
  logic x3, x2, x1, x0;
  logic y3, y2, y1, y0;
  logic carryin;
  logic s3, s2, s1, s0;
  logic carryout;

  modport master (
    output x3, x2, x1, x0, y3, y2, y1, y0, carryin,
    input  s3, s2, s1, s0, carryout
  );
  modport slave (
    input  x3, x2, x1, x0, y3, y2, y1, y0, carryin,
    output s3, s2, s1, s0, carryout
  );
endinterface

// File: rtl/adder_4bit_full_adder.sv
// One-bit full-adder cell. It is purely combinational.
// Ports:
//   a, b - operand bits
//   cin  - carry in
//   sum  - a ^ b ^ cin
//   cout - carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic w_p;

  // The propagate term is shared by the sum and the carry.
  assign w_p  = a ^ b;
  assign sum  = w_p ^ cin;
  assign cout = (a & b) | (cin & w_p);
endmodule

// File: rtl/adder_4bit.sv
// Registered 4-bit ripple-carry adder:
//   {carryout,s3..s0} <= X + Y + carryin
// The result appears one clock after the operands are applied.
// Ports:
//   clk       - rising-edge clock
//   rst       - synchronous active-high reset; it clears the result register
//   x3..x0    - operand X, MSB first
//   y3..y0    - operand Y, MSB first
//   carryin   - carry into bit 0
//   s3..s0    - registered sum, MSB first
//   carryout  - registered carry out of bit 3
module adder_4bit
  import adder_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic x3, x2, x1, x0,
  input  logic y3, y2, y1, y0,
  input  logic carryin,
  output logic s3, s2, s1, s0,
  output logic carryout
);
  nibble_t                w_x, w_y, w_sum;
  logic [ADDER_WIDTH:0]   w_c;   // w_c[i] is the carry into bit i
  nibble_sum_t            r_out;

  assign w_x    = {x3, x2, x1, x0};
  assign w_y    = {y3, y2, y1, y0};
  assign w_c[0] = carryin;

  for (genvar i = 0; i < ADDER_WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a   (w_x[i]),
      .b   (w_y[i]),
      .cin (w_c[i]),
      .sum (w_sum[i]),
      .cout(w_c[i+1])
    );
  end

  // Reset takes priority, so a reset cycle discards that cycle's add.
  always_ff @(posedge clk) begin
    if (rst) r_out <= '0;
    else     r_out <= {w_c[ADDER_WIDTH], w_sum};
  end

  // The outputs come only from the register. No input reaches them combinationally.
  assign {carryout, s3, s2, s1, s0} = r_out;
endmodule

// File: tb/tb_adder_4bit.sv
// Directed and exhaustive checks for adder_4bit.
module tb_adder_4bit;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  adder_4bit_if bus();

  adder_4bit dut (
    .clk     (clk),
    .rst     (rst),
    .x3      (bus.x3), .x2(bus.x2), .x1(bus.x1), .x0(bus.x0),
    .y3      (bus.y3), .y2(bus.y2), .y1(bus.y1), .y0(bus.y0),
    .carryin (bus.carryin),
    .s3      (bus.s3), .s2(bus.s2), .s1(bus.s1), .s0(bus.s0),
    .carryout(bus.carryout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic       cin;
    logic [4:0] exp;   // {carryout, s3..s0}
  } vec_t;

  task automatic drive(input logic [3:0] x, input logic [3:0] y, input logic c);
    {bus.x3, bus.x2, bus.x1, bus.x0} = x;
    {bus.y3, bus.y2, bus.y1, bus.y0} = y;
    bus.carryin = c;
  endtask

  task automatic check(input string name, input logic [4:0] exp);
    logic [4:0] got;
    got = {bus.carryout, bus.s3, bus.s2, bus.s1, bus.s0};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  // Wait for the edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{4'h0, 4'h0, 1'b0, 5'b0_0000};
    vecs[1] = '{4'h1, 4'h1, 1'b0, 5'b0_0010};
    vecs[2] = '{4'h1, 4'h1, 1'b1, 5'b0_0011};
    vecs[3] = '{4'hA, 4'h5, 1'b0, 5'b0_1111};
    vecs[4] = '{4'hC, 4'hD, 1'b1, 5'b1_1010};
    vecs[5] = '{4'hF, 4'hF, 1'b0, 5'b1_1110};
    vecs[6] = '{4'h0, 4'h1, 1'b1, 5'b0_0010};
    vecs[7] = '{4'hF, 4'h0, 1'b1, 5'b1_0000};

    // Reset holds the outputs at zero even with the maximum operands applied.
    rst = 1'b1;
    drive(4'hF, 4'hF, 1'b1);
    tick(); check("reset_cyc1", 5'h00);
    tick(); check("reset_cyc2", 5'h00);
    rst = 1'b0;
    #2 check("reset_hold_before_edge", 5'h00);
    tick(); check("first_after_reset_F+F+1", 5'h1F);

    // Table vectors. Each result must appear exactly one edge after its operands are applied.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].x, vecs[i].y, vecs[i].cin);
      #1 check($sformatf("no_comb_path_%0d", i), (i == 0) ? 5'h1F : vecs[i-1].exp);
      tick();
      check($sformatf("vec_%0d", i), vecs[i].exp);
    end

    // Additional boundary case: carry-in alone.
    drive(4'h0, 4'h0, 1'b1);
    tick(); check("cin_only", 5'h01);

    // Back-to-back operands with a one-cycle reset pulse in the middle.
    drive(4'h3, 4'h4, 1'b0);
    tick(); check("b2b_before", 5'h07);
    drive(4'h9, 4'h9, 1'b1);
    rst = 1'b1;
    tick(); check("b2b_reset", 5'h00);
    rst = 1'b0;
    drive(4'h8, 4'h8, 1'b0);
    tick(); check("b2b_after", 5'h10);
    drive(4'h7, 4'h2, 1'b1);
    tick(); check("b2b_after2", 5'h0A);

    // Exhaustive sweep with one new input set every cycle.
    // Each result is checked against the expected value from the previous cycle.
    begin
      logic [4:0] exp_prev;
      logic       have_prev;
      int         sweep_bad;
      int         fails_before;
      have_prev    = 1'b0;
      exp_prev     = '0;
      sweep_bad    = 0;
      fails_before = n_fail;
      for (int k = 0; k < 512; k++) begin
        logic [3:0] xx, yy;
        logic       cc;
        xx = k[8:5];
        yy = k[4:1];
        cc = k[0];
        drive(xx, yy, cc);
        tick();
        check($sformatf("sweep_%0d", k), 5'(xx) + 5'(yy) + 5'(cc));
        exp_prev  = 5'(xx) + 5'(yy) + 5'(cc);
        have_prev = 1'b1;
      end
      // The output must still hold the last result until the next edge.
      if (have_prev) begin
        #3 check("sweep_hold", exp_prev);
      end
      sweep_bad = n_fail - fails_before;
      if (sweep_bad != 0) $display("sweep: %0d bad results", sweep_bad);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
